axi_write_arbiter: RTL and testbench



---
 rtl/axi_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/axi_write_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_arb_pkg
// Shared types and AXI encodings for the AXI write arbiter.
// Rev    : 1.0
// ============================================================================
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin pick: first request at or after rr_ptr_i, wrapping.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
    output logic [NREQ-1:0]         gnt_o
);

    localparam int PW   = $clog2(NREQ);
    localparam int SUMW = PW + 1;
    localparam logic [SUMW-1:0] NREQ_W = SUMW'(NREQ);

    logic            found;
    logic [SUMW-1:0] sum;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Extra sum bit lets the wrap work for non-power-of-two NREQ.
            sum = {1'b0, rr_ptr_i} + SUMW'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!found && req_i[sum[PW-1:0]]) begin
                gnt_o[sum[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi_write_arbiter
// Round-robin sharing of one AXI write master among NREQ full AW/W/B requesters.
// Rev    : 1.0
// ============================================================================
module axi_write_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [NREQ*AW-1:0]     req_awaddr,
    input  logic [NREQ*8-1:0]      req_awlen,
    input  logic [NREQ*3-1:0]      req_awsize,
    input  logic [NREQ*2-1:0]      req_awburst,
    input  logic [NREQ-1:0]        req_awvalid,
    output logic [NREQ-1:0]        req_awready,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_wstrb,
    input  logic [NREQ-1:0]        req_wvalid,
    output logic [NREQ-1:0]        req_wready,
    input  logic [NREQ-1:0]        req_bready,
    output logic [NREQ-1:0]        req_bvalid,
    output logic [1:0]             req_bresp,

    output logic [AW-1:0]          m_awaddr,
    output logic [7:0]             m_awlen,
    output logic [2:0]             m_awsize,
    output logic [1:0]             m_awburst,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [DW-1:0]          m_wdata,
    output logic [DW/8-1:0]        m_wstrb,
    output logic                   m_wlast,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready,

    output logic [NREQ-1:0]        grant,
    output logic                   busy
);

    localparam int PW = $clog2(NREQ);
    localparam int SW = DW / 8;

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic [NREQ-1:0] rr_gnt;
    logic [PW-1:0]   gidx;
    logic [AW-1:0]   sel_awaddr;
    logic [7:0]      sel_awlen;
    logic [2:0]      sel_awsize;
    logic [1:0]      sel_awburst;
    logic            sel_awvalid;
    logic [DW-1:0]   sel_wdata;
    logic [SW-1:0]   sel_wstrb;
    logic            sel_wvalid;
    logic            sel_bready;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i    (req_awvalid),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (rr_gnt)
    );

    // Mux the granted requester's slice; grant_q is one-hot or zero.
    always_comb begin
        gidx        = '0;
        sel_awaddr  = '0;
        sel_awlen   = '0;
        sel_awsize  = '0;
        sel_awburst = '0;
        sel_awvalid = 1'b0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        sel_wvalid  = 1'b0;
        sel_bready  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                gidx        = PW'(i);
                sel_awaddr  = req_awaddr[i*AW +: AW];
                sel_awlen   = req_awlen[i*8 +: 8];
                sel_awsize  = req_awsize[i*3 +: 3];
                sel_awburst = req_awburst[i*2 +: 2];
                sel_awvalid = req_awvalid[i];
                sel_wdata   = req_wdata[i*DW +: DW];
                sel_wstrb   = req_wstrb[i*SW +: SW];
                sel_wvalid  = req_wvalid[i];
                sel_bready  = req_bready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        req_awready = '0;
        req_wready  = '0;
        req_bvalid  = '0;
        req_bresp   = '0;
        m_awaddr    = '0;
        m_awlen     = '0;
        m_awsize    = '0;
        m_awburst   = '0;
        m_awvalid   = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wlast     = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_awvalid) begin
                    grant_d = rr_gnt;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_awvalid   = sel_awvalid;
                req_awready = grant_q & {NREQ{m_awready}};
                if (sel_awvalid) begin
                    m_awaddr  = sel_awaddr;
                    m_awlen   = sel_awlen;
                    m_awsize  = sel_awsize;
                    m_awburst = sel_awburst;
                end
                if (sel_awvalid && m_awready) begin
                    beat_cnt_d = sel_awlen;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                m_wvalid   = sel_wvalid;
                req_wready = grant_q & {NREQ{m_wready}};
                m_wlast    = (beat_cnt_q == 8'd0);
                if (sel_wvalid) begin
                    m_wdata = sel_wdata;
                    m_wstrb = sel_wstrb;
                end
                // The last beat leaves DATA, so the counter never wraps below zero.
                if (sel_wvalid && m_wready) begin
                    if (beat_cnt_q == 8'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            ST_RESP: begin
                m_bready   = sel_bready;
                req_bvalid = grant_q & {NREQ{m_bvalid}};
                if (m_bvalid) begin
                    req_bresp = m_bresp;
                end
                if (m_bvalid && sel_bready) begin
                    rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_write_arbiter
// Self-checking bench: scenario table, reset corner case and random traffic.
// Rev    : 1.0
// ============================================================================
module tb_axi_write_arbiter;
    import axi_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ*AW-1:0]   req_awaddr;
    logic [NREQ*8-1:0]    req_awlen;
    logic [NREQ*3-1:0]    req_awsize;
    logic [NREQ*2-1:0]    req_awburst;
    logic [NREQ-1:0]      req_awvalid, req_awready;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_wstrb;
    logic [NREQ-1:0]      req_wvalid, req_wready;
    logic [NREQ-1:0]      req_bready, req_bvalid;
    logic [1:0]           req_bresp;
    logic [AW-1:0]        m_awaddr;
    logic [7:0]           m_awlen;
    logic [2:0]           m_awsize;
    logic [1:0]           m_awburst;
    logic                 m_awvalid, m_awready;
    logic [DW-1:0]        m_wdata;
    logic [SW-1:0]        m_wstrb;
    logic                 m_wlast, m_wvalid, m_wready;
    logic [1:0]           m_bresp;
    logic                 m_bvalid, m_bready;
    logic [NREQ-1:0]      grant;
    logic                 busy;

    axi_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_awaddr(req_awaddr), .req_awlen(req_awlen), .req_awsize(req_awsize),
        .req_awburst(req_awburst), .req_awvalid(req_awvalid), .req_awready(req_awready),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_wvalid(req_wvalid),
        .req_wready(req_wready), .req_bready(req_bready), .req_bvalid(req_bvalid),
        .req_bresp(req_bresp),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Requester-side traffic state.
    int            rq_left  [NREQ];
    int            rq_len   [NREQ];
    int            rq_wsent [NREQ];
    int            rq_tag   [NREQ];
    bit            rq_awd   [NREQ];
    logic [AW-1:0] rq_addr  [NREQ];

    // Row configuration and slave behaviour.
    bit         r_rnd;
    int         r_bdelay;
    logic [1:0] r_bresp;
    bit         b_pend;
    int         b_cnt;

    // Transaction-level reference model.
    int         m_ptr, m_cur, m_pick, m_n;
    bit         m_idle, m_expg;
    logic [7:0] order_log;
    int         row_beats;

    typedef struct {
        int         n0, n1, len0, len1;
        bit         rnd;
        int         bdelay;
        logic [1:0] bresp;
        logic [7:0] exp_order;
        int         exp_beats;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] wd(input int i, input int tag, input int beat);
        return {8'(i), 8'(tag), 16'hA5C3, 32'(beat)};
    endfunction

    function automatic logic [7:0] ws(input int i, input int tag, input int beat);
        return 8'(i * 37 + tag * 11 + beat * 5 + 1);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit all_done();
        for (int i = 0; i < NREQ; i++) if (rq_left[i] > 0) return 1'b0;
        return m_idle && !m_expg;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_awvalid[i]            = (rq_left[i] > 0) && !rq_awd[i];
            req_awaddr[i*AW +: AW]    = rq_addr[i];
            req_awlen[i*8 +: 8]       = 8'(rq_len[i]);
            req_awsize[i*3 +: 3]      = 3'd3;
            req_awburst[i*2 +: 2]     = BURST_INCR;
            req_wvalid[i]             = (rq_left[i] > 0) && (rq_wsent[i] <= rq_len[i]);
            req_wdata[i*DW +: DW]     = wd(i, rq_tag[i], rq_wsent[i]);
            req_wstrb[i*SW +: SW]     = ws(i, rq_tag[i], rq_wsent[i]);
            req_bready[i]             = r_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        m_awready = r_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_wready  = r_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_bvalid  = b_pend && (b_cnt == 0);
        m_bresp   = m_bvalid ? r_bresp : 2'd0;
    endtask

    task automatic sample();
        chk("nongrant_quiet", 64'((req_awready | req_wready | req_bvalid) & ~grant), 64'd0);
        if (!m_awvalid) chk("aw_payload_zero", 64'({m_awaddr, m_awlen, m_awsize, m_awburst}), 64'd0);
        if (!m_wvalid)  chk("w_payload_zero", m_wdata | 64'(m_wstrb), 64'd0);

        if (m_expg) begin
            chk("grant_after_arb", 64'(grant), 64'(1 << m_pick));
            chk("awvalid_after_arb", 64'(m_awvalid), 64'd1);
            m_cur     = m_pick;
            m_expg    = 1'b0;
            order_log = {order_log[5:0], grant};
        end
        if (m_idle) begin
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_grant", 64'(grant), 64'd0);
            if (|req_awvalid) begin
                m_pick = rr_pick(req_awvalid, m_ptr);
                m_idle = 1'b0;
                m_expg = 1'b1;
            end
        end

        if (m_awvalid && m_awready) begin
            chk("aw_addr", 64'(m_awaddr), 64'(rq_addr[m_cur]));
            chk("aw_len", 64'(m_awlen), 64'(rq_len[m_cur]));
            chk("aw_size_burst", 64'({m_awsize, m_awburst}), 64'({3'd3, BURST_INCR}));
            chk("aw_ready_fwd", 64'(req_awready), 64'(1 << m_cur));
            m_n = 0;
        end

        if (b_pend && b_cnt > 0) b_cnt--;

        if (m_wvalid && m_wready) begin
            chk("w_data", m_wdata, wd(m_cur, rq_tag[m_cur], m_n));
            chk("w_strb", 64'(m_wstrb), 64'(ws(m_cur, rq_tag[m_cur], m_n)));
            chk("w_last", 64'(m_wlast), 64'(m_n == rq_len[m_cur]));
            row_beats++;
            if (m_n == rq_len[m_cur]) begin
                b_pend = 1'b1;
                b_cnt  = r_bdelay;
            end
            m_n++;
        end

        if (m_bvalid && m_bready) begin
            chk("b_valid_route", 64'(req_bvalid), 64'(1 << m_cur));
            chk("b_resp", 64'(req_bresp), 64'(r_bresp));
            m_ptr  = (m_cur + 1) % NREQ;
            m_idle = 1'b1;
            b_pend = 1'b0;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (req_awvalid[i] && req_awready[i]) rq_awd[i] = 1'b1;
            if (req_wvalid[i] && req_wready[i]) rq_wsent[i]++;
            if (req_bvalid[i] && req_bready[i]) begin
                rq_left[i]--;
                rq_awd[i]   = 1'b0;
                rq_wsent[i] = 0;
                rq_tag[i]++;
                rq_addr[i]  = AW'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run_row(input int max_cycles);
        int cyc;
        cyc = 0;
        while (!all_done()) begin
            step();
            cyc++;
            if (cyc > max_cycles) begin
                chk("row_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rq_left[i]  = 0;
            rq_awd[i]   = 1'b0;
            rq_wsent[i] = 0;
            rq_tag[i]   = i * 64;
            rq_addr[i]  = AW'($urandom);
        end
        req_awvalid = '1; req_wvalid = '1; req_bready = '1;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = RESP_SLVERR;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_side", 64'({req_awready, req_wready, req_bvalid, req_bresp}), 64'd0);
        chk("rst_master_side", 64'({m_awvalid, m_wvalid, m_wlast, m_bready, m_awaddr}), 64'd0);
        chk("rst_grant_busy", 64'({grant, busy}), 64'd0);
        req_awvalid = '0; req_wvalid = '0; req_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'd0;
        rst_n = 1'b1;
        m_ptr = 0; m_cur = 0; m_pick = 0; m_n = 0;
        m_idle = 1'b1; m_expg = 1'b0;
        b_pend = 1'b0; b_cnt = 0;
        order_log = '0; row_beats = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        req_awaddr = '0; req_awlen = '0; req_awsize = '0; req_awburst = '0;
        req_wdata = '0; req_wstrb = '0;
        r_rnd = 1'b0; r_bdelay = 0; r_bresp = RESP_OKAY;

        //            n0 n1 len0 len1 rnd bdly bresp        order  beats
        tbl[0] = '{1, 0, 3,   0,   0,  0,   RESP_OKAY,   8'h01, 4};
        tbl[1] = '{2, 1, 1,   2,   0,  0,   RESP_OKAY,   8'h19, 7};
        tbl[2] = '{1, 0, 0,   0,   0,  0,   RESP_OKAY,   8'h01, 1};
        tbl[3] = '{0, 1, 0,   255, 0,  0,   RESP_OKAY,   8'h02, 256};
        tbl[4] = '{1, 1, 4,   2,   1,  5,   RESP_SLVERR, 8'h06, 8};

        for (int r = 0; r < 5; r++) begin
            do_reset();
            r_rnd = tbl[r].rnd; r_bdelay = tbl[r].bdelay; r_bresp = tbl[r].bresp;
            rq_left[0] = tbl[r].n0;   rq_left[1] = tbl[r].n1;
            rq_len[0]  = tbl[r].len0; rq_len[1]  = tbl[r].len1;
            run_row(2000);
            chk($sformatf("row%0d_grant_order", r), 64'(order_log), 64'(tbl[r].exp_order));
            chk($sformatf("row%0d_beats", r), 64'(row_beats), 64'(tbl[r].exp_beats));
        end

        // Reset in the middle of a burst, after the pointer has moved to 1.
        do_reset();
        r_rnd = 1'b0; r_bdelay = 0; r_bresp = RESP_OKAY;
        rq_left[0] = 1; rq_len[0] = 0;
        run_row(100);
        rq_left[0] = 1; rq_len[0] = 5;
        cyc = 0;
        while (rq_wsent[0] < 2 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("mid_beats_before_rst", 64'(rq_wsent[0]), 64'd2);
        @(posedge clk);
        #1;
        drive();
        chk("pre_rst_in_data", 64'({m_wvalid, busy}), 64'b11);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_w", 64'({m_wvalid, m_wlast, req_wready}), 64'd0);
        chk("async_rst_state", 64'({grant, busy, m_awvalid, m_bready}), 64'd0);
        do_reset();
        rq_left[0] = 1; rq_left[1] = 1; rq_len[0] = 1; rq_len[1] = 1;
        run_row(200);
        chk("post_rst_grant_order", 64'(order_log), 64'h06);

        do_reset();
        r_rnd = 1'b0;
        rq_left[1] = 1; rq_len[1] = 2;
        run_row(100);
        chk("post_rst_req1_only", 64'(order_log), 64'h02);

        // Random traffic; the pointer carries across rounds without reset.
        do_reset();
        for (int it = 0; it < 10; it++) begin
            r_rnd    = 1'b1;
            r_bdelay = $urandom_range(0, 6);
            r_bresp  = $urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY;
            for (int i = 0; i < NREQ; i++) begin
                rq_left[i] = $urandom_range(0, 3);
                rq_len[i]  = $urandom_range(0, 15);
            end
            run_row(4000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
